// File: rtl/pipelined_addsub_if.sv
// rtl/pipelined_addsub_if.sv - operand/result handshake bundle for pipelined_addsub
interface pipelined_addsub_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] res;
   logic             cout;
   logic             ovf;
   logic             zero;

   modport master (
      output in_valid, a, b, cin, op, out_ready,
      input  in_ready, out_valid, res, cout, ovf, zero
   );

   modport slave (
      input  in_valid, a, b, cin, op, out_ready,
      output in_ready, out_valid, res, cout, ovf, zero
   );
endinterface

// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - chunked multi-stage adder/subtractor with valid/ready flow control
module pipelined_addsub #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   pipelined_addsub_if.slave bus
);
   localparam int CHUNK = WIDTH / STAGES;
   localparam int MSB   = WIDTH - 1;

   // Values entering stage k: stage 0 sees the bus, later stages see the
   // registers of the stage before them.
   logic [WIDTH-1:0] w_a  [STAGES];
   logic [WIDTH-1:0] w_b  [STAGES];
   logic [WIDTH-1:0] w_r  [STAGES];
   logic             w_c  [STAGES];
   logic             w_op [STAGES];
   logic             w_v  [STAGES];
   logic             w_stall;

   // A held result at the output freezes the whole pipe and blocks intake.
   assign w_stall      = bus.out_valid && !bus.out_ready;
   assign bus.in_ready = !w_stall;

   assign w_a[0]  = bus.a;
   assign w_b[0]  = bus.b;
   assign w_r[0]  = '0;
   assign w_c[0]  = bus.cin;
   assign w_op[0] = bus.op;
   assign w_v[0]  = bus.in_valid;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic             r_v;
      logic             r_c;
      logic [WIDTH-1:0] r_res;
      logic [CHUNK:0]   w_sum;
      logic [WIDTH-1:0] w_res_next;

      // Subtract is a + ~b + !borrow; carry/borrow travels in its native
      // sense between stages, so only the adder inputs/outputs get flipped.
      always_comb begin
         w_sum = {1'b0, w_a[k][k*CHUNK +: CHUNK]}
               + {1'b0, w_b[k][k*CHUNK +: CHUNK] ^ {CHUNK{w_op[k]}}}
               + {{CHUNK{1'b0}}, w_c[k] ^ w_op[k]};
         w_res_next = w_r[k];
         w_res_next[k*CHUNK +: CHUNK] = w_sum[CHUNK-1:0];
      end

      // Stage slot: valid, chunk carry and accumulated result advance unless stalled.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_v   <= 1'b0;
            r_c   <= 1'b0;
            r_res <= '0;
         end else if (!w_stall) begin
            r_v   <= w_v[k];
            r_c   <= w_sum[CHUNK] ^ w_op[k];
            r_res <= w_res_next;
         end
      end

      if (k < STAGES - 1) begin : g_fwd
         logic [WIDTH-1:0] r_a;
         logic [WIDTH-1:0] r_b;
         logic             r_op;

         // Operands and op ride along so later stages can process their chunk.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_a  <= '0;
               r_b  <= '0;
               r_op <= 1'b0;
            end else if (!w_stall) begin
               r_a  <= w_a[k];
               r_b  <= w_b[k];
               r_op <= w_op[k];
            end
         end

         assign w_a[k+1]  = r_a;
         assign w_b[k+1]  = r_b;
         assign w_r[k+1]  = r_res;
         assign w_c[k+1]  = r_c;
         assign w_op[k+1] = r_op;
         assign w_v[k+1]  = r_v;
      end else begin : g_last
         logic r_ovf;
         logic r_zero;
         logic w_ovf;

         // Signed overflow needs the sign bits, which only the top chunk sees complete.
         always_comb begin
            w_ovf = 1'b0;
            if (w_op[k]) begin
               w_ovf = (w_a[k][MSB] != w_b[k][MSB]) && (w_res_next[MSB] != w_a[k][MSB]);
            end else begin
               w_ovf = (w_a[k][MSB] == w_b[k][MSB]) && (w_res_next[MSB] != w_a[k][MSB]);
            end
         end

         // Flags are registered alongside the final result slot.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_ovf  <= 1'b0;
               r_zero <= 1'b0;
            end else if (!w_stall) begin
               r_ovf  <= w_ovf;
               r_zero <= (w_res_next == '0);
            end
         end

         assign bus.out_valid = r_v;
         assign bus.res       = r_res;
         assign bus.cout      = r_c;
         assign bus.ovf       = r_ovf;
         assign bus.zero      = r_zero;
      end
   end
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb/tb_pipelined_addsub.sv - directed and randomised checks for pipelined_addsub
module tb_pipelined_addsub;
   typedef struct {
      logic       op;
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] res;
      logic       cout;
      logic       ovf;
      logic       zero;
   } vec_t;

   typedef struct packed {
      logic [15:0] res;
      logic        cout;
      logic        ovf;
      logic        zero;
   } exp_t;

   logic clk;
   logic rst_n;
   logic rand_go;
   int   n_checks;
   int   n_errors;
   vec_t vt [12];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   pipelined_addsub_if #(.WIDTH(8)) bus ();
   pipelined_addsub #(.WIDTH(8), .STAGES(2)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t model16(input logic [15:0] a, input logic [15:0] b,
                                    input logic cin, input logic op);
      exp_t        e;
      logic [16:0] full;
      if (op) begin
         e.res  = a - b - 16'(cin);
         e.cout = ({1'b0, a} < ({1'b0, b} + {16'b0, cin}));
         e.ovf  = (a[15] != b[15]) && (e.res[15] != a[15]);
      end else begin
         full   = {1'b0, a} + {1'b0, b} + {16'b0, cin};
         e.res  = full[15:0];
         e.cout = full[16];
         e.ovf  = (a[15] == b[15]) && (e.res[15] != a[15]);
      end
      e.zero = (e.res == 16'h0);
      return e;
   endfunction

   task automatic apply_vec(input vec_t v, input int idx);
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.op        = v.op;
      bus.a         = v.a;
      bus.b         = v.b;
      bus.cin       = v.cin;
      bus.out_ready = 1'b1;
      #1 chk($sformatf("v%0d_in_ready", idx), 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1 chk($sformatf("v%0d_early_valid", idx), 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      #1;
      chk($sformatf("v%0d_valid", idx), 32'(bus.out_valid), 32'd1);
      chk($sformatf("v%0d_res", idx), 32'(bus.res), 32'(v.res));
      chk($sformatf("v%0d_cout", idx), 32'(bus.cout), 32'(v.cout));
      chk($sformatf("v%0d_ovf", idx), 32'(bus.ovf), 32'(v.ovf));
      chk($sformatf("v%0d_zero", idx), 32'(bus.zero), 32'(v.zero));
   endtask

   for (genvar g = 0; g < 3; g++) begin : g_rnd
      localparam int STG = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
      logic done;
      pipelined_addsub_if #(.WIDTH(16)) rbus ();
      pipelined_addsub #(.WIDTH(16), .STAGES(STG)) u_dut (.clk(clk), .rst_n(rst_n), .bus(rbus));

      initial begin : rnd_proc
         exp_t q[$];
         exp_t e;
         exp_t prev;
         logic prev_stall;
         done           = 1'b0;
         rbus.in_valid  = 1'b0;
         rbus.out_ready = 1'b1;
         rbus.a         = '0;
         rbus.b         = '0;
         rbus.cin       = 1'b0;
         rbus.op        = 1'b0;
         prev_stall     = 1'b0;
         prev           = '0;
         wait (rand_go);
         for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            rbus.in_valid  = (n < 350) && ($urandom_range(3) != 0);
            rbus.out_ready = (n >= 350) || ($urandom_range(9) < 6);
            rbus.a         = 16'($urandom);
            rbus.b         = 16'($urandom);
            rbus.cin       = 1'($urandom);
            rbus.op        = 1'($urandom);
            #1;
            if (prev_stall) begin
               chk($sformatf("rnd%0d_hold", STG), 32'({rbus.res, rbus.cout, rbus.ovf, rbus.zero}), 32'(prev));
            end
            if (rbus.in_valid && rbus.in_ready) begin
               q.push_back(model16(rbus.a, rbus.b, rbus.cin, rbus.op));
            end
            if (rbus.out_valid && rbus.out_ready) begin
               if (q.size() == 0) begin
                  chk($sformatf("rnd%0d_spurious", STG), 32'd1, 32'd0);
               end else begin
                  e = q.pop_front();
                  chk($sformatf("rnd%0d_res", STG), 32'(rbus.res), 32'(e.res));
                  chk($sformatf("rnd%0d_flags", STG), 32'({rbus.cout, rbus.ovf, rbus.zero}),
                      32'({e.cout, e.ovf, e.zero}));
               end
            end
            prev_stall = rbus.out_valid && !rbus.out_ready;
            prev       = {rbus.res, rbus.cout, rbus.ovf, rbus.zero};
         end
         chk($sformatf("rnd%0d_drained", STG), 32'(q.size()), 32'd0);
         done = 1'b1;
      end
   end

   initial begin : main
      int   sent;
      int   got;
      logic was_stall;
      logic [7:0] held;
      n_checks      = 0;
      n_errors      = 0;
      rand_go       = 1'b0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.a         = '0;
      bus.b         = '0;
      bus.cin       = 1'b0;
      bus.op        = 1'b0;

      vt[0]  = '{1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0};
      vt[1]  = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
      vt[2]  = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
      vt[3]  = '{1'b1, 8'h3C, 8'h3B, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
      vt[4]  = '{1'b0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
      vt[5]  = '{1'b0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0};
      vt[6]  = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
      vt[7]  = '{1'b1, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
      vt[8]  = '{1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0};
      vt[9]  = '{1'b1, 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0};
      vt[10] = '{1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
      vt[11] = '{1'b1, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0};

      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_outputs", 32'({bus.res, bus.cout, bus.ovf, bus.zero}), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) apply_vec(vt[i], i);

      sent      = 0;
      got       = 0;
      was_stall = 1'b0;
      held      = '0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         bus.in_valid  = (sent < 5);
         bus.op        = 1'b0;
         bus.cin       = 1'b0;
         bus.a         = 8'(16 * (sent + 1));
         bus.b         = 8'(sent + 1);
         bus.out_ready = !(c >= 2 && c <= 6);
         #1;
         if (c >= 2 && c <= 6) chk($sformatf("stall_in_ready_c%0d", c), 32'(bus.in_ready), 32'd0);
         if (was_stall) chk($sformatf("stall_hold_c%0d", c), 32'(bus.res), 32'(held));
         if (bus.out_valid && bus.out_ready) begin
            chk($sformatf("stall_res%0d", got), 32'(bus.res), 32'(17 * (got + 1)));
            got++;
         end
         if (bus.in_valid && bus.in_ready) sent++;
         was_stall = bus.out_valid && !bus.out_ready;
         held      = bus.res;
      end
      chk("stall_sent", 32'(sent), 32'd5);
      chk("stall_got", 32'(got), 32'd5);

      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      bus.op        = 1'b0;
      bus.cin       = 1'b0;
      bus.a         = 8'h01;
      bus.b         = 8'h01;
      @(negedge clk);
      bus.a = 8'h02;
      bus.b = 8'h02;
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1 chk("inflight_valid", 32'(bus.out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rstpulse_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rstpulse_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rstpulse_outputs", 32'({bus.res, bus.cout, bus.ovf, bus.zero}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         #1 chk($sformatf("rstpulse_ghost_c%0d", c), 32'(bus.out_valid), 32'd0);
      end
      apply_vec(vt[5], 100);

      rand_go = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (g_rnd[0].done && g_rnd[1].done && g_rnd[2].done) break;
      end
      chk("rnd_all_done", 32'({g_rnd[0].done, g_rnd[1].done, g_rnd[2].done}), 32'h7);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
